controlador_semaforo: RTL and testbench

Moore state machine for a two-way (A = main road, B = side road) traffic-light intersection. Consumes the 1 Hz single-cycle tick produced by the frequency divider and sequences green, yellow and all-red phases with per-phase durations counted in ticks. Main road A holds green until side road B asserts demand. Sits between the divider and the lamp drivers / seven-segment countdown display.

---
 rtl/semaforo_pkg.sv | 38 +++
 rtl/controlador_semaforo.sv | 97 +++++++++
 tb/tb_controlador_semaforo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-road traffic-light controller: state codes,
// lamp codes, default phase durations and the state-to-lamp decode.
package semaforo_pkg;

  typedef enum logic [2:0] {
    VERDE_A    = 3'd0,
    AMARILLO_A = 3'd1,
    ROJO_AB1   = 3'd2,
    VERDE_B    = 3'd3,
    AMARILLO_B = 3'd4,
    ROJO_AB2   = 3'd5
  } estado_t;

  localparam logic [2:0] LUZ_ROJO     = 3'b100;
  localparam logic [2:0] LUZ_AMARILLO = 3'b010;
  localparam logic [2:0] LUZ_VERDE    = 3'b001;

  localparam int unsigned T_VERDE_DEF    = 10;
  localparam int unsigned T_AMARILLO_DEF = 3;
  localparam int unsigned T_ROJO_DEF     = 1;

  // Returns {luces_A, luces_B}; any code outside the six states decodes all-red.
  function automatic logic [5:0] decodificar_luces(input estado_t e);
    logic [5:0] r;
    r = {LUZ_ROJO, LUZ_ROJO};
    case (e)
      VERDE_A:    r = {LUZ_VERDE,    LUZ_ROJO};
      AMARILLO_A: r = {LUZ_AMARILLO, LUZ_ROJO};
      ROJO_AB1:   r = {LUZ_ROJO,     LUZ_ROJO};
      VERDE_B:    r = {LUZ_ROJO,     LUZ_VERDE};
      AMARILLO_B: r = {LUZ_ROJO,     LUZ_AMARILLO};
      ROJO_AB2:   r = {LUZ_ROJO,     LUZ_ROJO};
      default:    r = {LUZ_ROJO,     LUZ_ROJO};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/controlador_semaforo.sv
// Moore sequencer for a main road (A) / side road (B) intersection, advancing
// its phase counter on each divider tick.
//
// state      | meaning
// VERDE_A    | A green, B red; held past expiry until B demands
// AMARILLO_A | A yellow, B red
// ROJO_AB1   | all red, clearing before B
// VERDE_B    | A red, B green
// AMARILLO_B | A red, B yellow
// ROJO_AB2   | all red, clearing before A (also the reset state)
module controlador_semaforo
  import semaforo_pkg::*;
#(
  parameter int unsigned T_VERDE    = T_VERDE_DEF,
  parameter int unsigned T_AMARILLO = T_AMARILLO_DEF,
  parameter int unsigned T_ROJO     = T_ROJO_DEF
) (
  input  logic       clk_Entrada,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       demanda_B,
  output logic [2:0] luces_A,
  output logic [2:0] luces_B,
  output logic [2:0] estado,
  output logic [7:0] cuenta
);

  localparam logic [7:0] CARGA_VERDE    = 8'(T_VERDE - 1);
  localparam logic [7:0] CARGA_AMARILLO = 8'(T_AMARILLO - 1);
  localparam logic [7:0] CARGA_ROJO     = 8'(T_ROJO - 1);

  estado_t    est_q, est_d;
  logic [7:0] cuenta_d;

  always_comb begin
    est_d    = est_q;
    cuenta_d = cuenta;
    if (est_q > ROJO_AB2) begin
      est_d    = ROJO_AB2;
      cuenta_d = CARGA_ROJO;
    end else if (tick_1hz) begin
      if (cuenta != 8'd0) begin
        cuenta_d = cuenta - 8'd1;
      end else begin
        // Phase expired; VERDE_A simply stays with cuenta at 0 without demand.
        case (est_q)
          VERDE_A: begin
            if (demanda_B) begin
              est_d    = AMARILLO_A;
              cuenta_d = CARGA_AMARILLO;
            end
          end
          AMARILLO_A: begin
            est_d    = ROJO_AB1;
            cuenta_d = CARGA_ROJO;
          end
          ROJO_AB1: begin
            est_d    = VERDE_B;
            cuenta_d = CARGA_VERDE;
          end
          VERDE_B: begin
            est_d    = AMARILLO_B;
            cuenta_d = CARGA_AMARILLO;
          end
          AMARILLO_B: begin
            est_d    = ROJO_AB2;
            cuenta_d = CARGA_ROJO;
          end
          ROJO_AB2: begin
            est_d    = VERDE_A;
            cuenta_d = CARGA_VERDE;
          end
          default: begin
            est_d    = ROJO_AB2;
            cuenta_d = CARGA_ROJO;
          end
        endcase
      end
    end
  end

  // Lamps are registered from the next state so they switch on the same edge.
  always_ff @(posedge clk_Entrada) begin
    if (rst) begin
      est_q              <= ROJO_AB2;
      cuenta             <= CARGA_ROJO;
      {luces_A, luces_B} <= {LUZ_ROJO, LUZ_ROJO};
    end else begin
      est_q              <= est_d;
      cuenta             <= cuenta_d;
      {luces_A, luces_B} <= decodificar_luces(est_d);
    end
  end

  assign estado = est_q;

endmodule

// File: tb/tb_controlador_semaforo.sv
// Self-checking bench: fixed vector table, directed corner sequences and a
// randomized run compared against a phase/elapsed-ticks reference model.
module tb_controlador_semaforo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       dem = 1'b0;
  logic [2:0] luces_A, luces_B, estado;
  logic [7:0] cuenta;

  int checks = 0;
  int errors = 0;

  controlador_semaforo #(.T_VERDE(3), .T_AMARILLO(2), .T_ROJO(1)) dut (
    .clk_Entrada(clk),
    .rst        (rst),
    .tick_1hz   (tick),
    .demanda_B  (dem),
    .luces_A    (luces_A),
    .luces_B    (luces_B),
    .estado     (estado),
    .cuenta     (cuenta)
  );

  always #5 clk = ~clk;

  // Reference model: phase index and ticks already spent in that phase.
  int         dur   [6] = '{3, 2, 1, 3, 2, 1};
  logic [2:0] ref_a [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ref_b [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_fase = 5;
  int m_trans = 0;
  bit armed = 0;
  bit rst_last = 0;

  task automatic model_update(input logic t, input logic d, input logic r);
    if (r) begin
      m_fase  = 5;
      m_trans = 0;
    end else if (t) begin
      if (m_trans + 1 < dur[m_fase]) m_trans++;
      else if (m_fase == 0 && !d) m_trans = dur[0] - 1;
      else begin
        m_fase  = (m_fase + 1) % 6;
        m_trans = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_estado", int'(estado), m_fase);
    check("model_cuenta", int'(cuenta), dur[m_fase] - 1 - m_trans);
    check("model_luces_A", int'(luces_A), int'(ref_a[m_fase]));
    check("model_luces_B", int'(luces_B), int'(ref_b[m_fase]));
  endtask

  task automatic step(input logic t, input logic d, input logic r);
    @(negedge clk);
    tick = t; dem = d; rst = r;
    @(posedge clk);
    model_update(t, d, r);
    rst_last = r;
    if (r) armed = 1;
    #1;
    check_model();
  endtask

  // Four idle clocks then one tick: tick every 5th clock.
  task automatic tick_cycle(input logic d);
    for (int k = 0; k < 4; k++) step(1'b0, d, 1'b0);
    step(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Safety: never both roads non-red; never green straight to red (except via reset).
  logic [2:0] prev_a = 3'b100, prev_b = 3'b100;
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (luces_A != 3'b100 && luces_B != 3'b100) begin
        errors++;
        $display("FAIL safety_both_open: A=%b B=%b expected one red", luces_A, luces_B);
      end
      checks++;
      if (!rst_last && ((prev_a == 3'b001 && luces_A == 3'b100) ||
                        (prev_b == 3'b001 && luces_B == 3'b100))) begin
        errors++;
        $display("FAIL safety_green_to_red: A %b->%b B %b->%b expected yellow between",
                 prev_a, luces_A, prev_b, luces_B);
      end
      prev_a = luces_A;
      prev_b = luces_B;
    end
  end

  typedef struct {
    logic       t, d, r;
    logic [2:0] e_est;
    logic [7:0] e_cnt;
    logic [2:0] e_a, e_b;
  } vec_t;

  vec_t tabla[$];

  initial begin
    int n;
    bit salio;

    tabla = '{
      '{1'b0, 1'b0, 1'b1, 3'd5, 8'd0, 3'b100, 3'b100},
      '{1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 3'b100, 3'b100},
      '{1'b0, 1'b0, 1'b0, 3'd5, 8'd0, 3'b100, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd0, 8'd2, 3'b001, 3'b100},
      '{1'b1, 1'b1, 1'b0, 3'd0, 8'd1, 3'b001, 3'b100},
      '{1'b0, 1'b1, 1'b0, 3'd0, 8'd1, 3'b001, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'b001, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'b001, 3'b100},
      '{1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 3'b001, 3'b100},
      '{1'b1, 1'b1, 1'b0, 3'd1, 8'd1, 3'b010, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd1, 8'd0, 3'b010, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 3'b100, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd3, 8'd2, 3'b100, 3'b001},
      '{1'b1, 1'b0, 1'b0, 3'd3, 8'd1, 3'b100, 3'b001},
      '{1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 3'b100, 3'b001},
      '{1'b1, 1'b0, 1'b0, 3'd4, 8'd1, 3'b100, 3'b010},
      '{1'b1, 1'b0, 1'b0, 3'd4, 8'd0, 3'b100, 3'b010},
      '{1'b1, 1'b0, 1'b0, 3'd5, 8'd0, 3'b100, 3'b100},
      '{1'b1, 1'b0, 1'b0, 3'd0, 8'd2, 3'b001, 3'b100}
    };

    for (int i = 0; i < tabla.size(); i++) begin
      step(tabla[i].t, tabla[i].d, tabla[i].r);
      check($sformatf("tab%0d_estado", i), int'(estado), int'(tabla[i].e_est));
      check($sformatf("tab%0d_cuenta", i), int'(cuenta), int'(tabla[i].e_cnt));
      check($sformatf("tab%0d_luces_A", i), int'(luces_A), int'(tabla[i].e_a));
      check($sformatf("tab%0d_luces_B", i), int'(luces_B), int'(tabla[i].e_b));
    end

    // Full cycle with constant demand takes exactly 12 ticks.
    do_reset();
    tick_cycle(1'b1);
    check("cycle_entry_estado", int'(estado), 0);
    check("cycle_entry_cuenta", int'(cuenta), 2);
    n = 0;
    salio = 0;
    for (int k = 0; k < 40; k++) begin
      tick_cycle(1'b1);
      n++;
      if (estado != 3'd0) salio = 1;
      if (salio && estado == 3'd0) break;
    end
    check("cycle_ticks", n, 12);

    // Reset in VERDE_B on a tick clock.
    for (int k = 0; k < 6; k++) tick_cycle(1'b1);
    check("pre_rst_estado", int'(estado), 3);
    check("pre_rst_cuenta", int'(cuenta), 2);
    step(1'b1, 1'b1, 1'b1);
    check("rst_vb_estado", int'(estado), 5);
    check("rst_vb_cuenta", int'(cuenta), 0);
    step(1'b0, 1'b1, 1'b0);

    // No demand: VERDE_A holds at cuenta 0 for 20 ticks, then demand advances.
    tick_cycle(1'b0);
    for (int k = 0; k < 20; k++) tick_cycle(1'b0);
    check("hold_estado", int'(estado), 0);
    check("hold_cuenta", int'(cuenta), 0);
    tick_cycle(1'b1);
    check("late_dem_estado", int'(estado), 1);
    check("late_dem_cuenta", int'(cuenta), 1);

    // Demand pulse between ticks is lost.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pulse_lost_estado", int'(estado), 0);
    check("pulse_lost_cuenta", int'(cuenta), 0);

    // Consecutive ticks in VERDE_B.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("vb_entry_estado", int'(estado), 3);
    check("vb_entry_cuenta", int'(cuenta), 2);
    step(1'b1, 1'b0, 1'b0);
    check("vb_c1", int'(cuenta), 1);
    step(1'b1, 1'b0, 1'b0);
    check("vb_c0", int'(cuenta), 0);
    step(1'b1, 1'b0, 1'b0);
    check("vb_exit_estado", int'(estado), 4);
    check("vb_exit_cuenta", int'(cuenta), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
